// File: rtl/cache_arbiter_pkg.sv
// rtl/cache_arbiter_pkg.sv - shared types for the I/D-cache memory port arbiter
package arb_types;

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} arb_state_t;
    typedef enum logic {ICACHE, DCACHE} arb_req_t;
    typedef enum logic {OP_READ, OP_WRITE} arb_op_t;

endpackage

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - round-robin arbiter sharing one memory line port between I-cache and D-cache
module cache_arbiter
    import arb_types::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    localparam int OFFSET = $clog2(LINE_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << OFFSET;

    arb_state_t            state_q, state_d;
    arb_req_t              last_q, last_d;
    arb_op_t               op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;

    logic i_req;
    logic d_req;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                // On contention the requester not served last wins.
                if (i_req && (!d_req || last_q == DCACHE)) begin
                    state_d = SERVE_I;
                    addr_d  = i_address & ALIGN_MASK;
                    wdata_d = '0;
                    op_d    = OP_READ;
                end else if (d_req) begin
                    state_d = SERVE_D;
                    addr_d  = d_address & ALIGN_MASK;
                    wdata_d = d_wdata;
                    op_d    = d_write ? OP_WRITE : OP_READ;
                end
            end
            SERVE_I: begin
                if (mem_resp) begin
                    state_d = IDLE;
                    last_d  = ICACHE;
                end
            end
            SERVE_D: begin
                if (mem_resp) begin
                    state_d = IDLE;
                    last_d  = DCACHE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= ICACHE;
            op_q    <= OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Memory side is driven purely from the latched request; responses go to the owner only.
    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        i_resp      = 1'b0;
        i_rdata     = '0;
        d_resp      = 1'b0;
        d_rdata     = '0;
        case (state_q)
            SERVE_I, SERVE_D: begin
                mem_read    = (op_q == OP_READ);
                mem_write   = (op_q == OP_WRITE);
                mem_address = addr_q;
                mem_wdata   = wdata_q;
                if (state_q == SERVE_I) begin
                    i_resp  = mem_resp;
                    i_rdata = mem_resp ? mem_rdata : '0;
                end else begin
                    d_resp  = mem_resp;
                    d_rdata = mem_resp ? mem_rdata : '0;
                end
            end
            default: ;
        endcase
    end

    a_d_read_write_exclusive: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - scoreboard bench for cache_arbiter with randomized request rounds
module tb_cache_arbiter;
    import arb_types::*;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read, d_read, d_write;
    logic [AW-1:0] i_address, d_address;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] i_rdata, d_rdata;
    logic          i_resp, d_resp;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_address;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata = '0;
    logic          mem_resp = 1'b0;

    always #5 clk = ~clk;

    cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    typedef struct {
        arb_req_t      who;
        logic [LW-1:0] data;
    } resp_t;

    int       errors = 0;
    int       checks = 0;
    arb_req_t grant_q[$];
    resp_t    resp_q[$];
    arb_req_t model_last = ICACHE;

    logic [AW-1:0] exp_i_addr = '0, exp_d_addr = '0;
    logic [LW-1:0] exp_d_wdata = '0;
    bit            exp_d_write = 1'b0;

    bit slow = 0, spur = 0, d_in_service = 0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
        return {a[AW-1:5], 5'b0};
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Memory responder and memory-side monitor.
    initial begin
        bit            busy = 0, resp_now = 0, phantom = 0, fire, pulse, cur_write = 0;
        arb_req_t      cur = ICACHE;
        logic [AW-1:0] cur_addr = '0;
        logic [LW-1:0] cur_wdata = '0;
        int            delay = 0;
        forever begin
            @(negedge clk);
            fire  = 0;
            pulse = 0;
            if (rst) begin
                busy = 0;
                d_in_service = 0;
            end else if (resp_now) begin
                busy = 0;
                d_in_service = 0;
            end else if (busy) begin
                if (!phantom) begin
                    chk("hold_addr", mem_address, cur_addr);
                    chk("hold_op", {mem_read, mem_write}, {!cur_write, cur_write});
                    if (cur_write) chk("hold_wdata", mem_wdata, cur_wdata);
                end
                if (delay == 0) fire = 1;
                else delay--;
            end else if (mem_read || mem_write) begin
                busy = 1;
                if (grant_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant: mem_read=%0b mem_write=%0b addr=%0h expected no grant",
                             mem_read, mem_write, mem_address);
                    phantom = 1;
                    delay = 0;
                end else begin
                    phantom   = 0;
                    cur       = grant_q.pop_front();
                    cur_addr  = (cur == ICACHE) ? align(exp_i_addr) : align(exp_d_addr);
                    cur_write = (cur == DCACHE) && exp_d_write;
                    cur_wdata = exp_d_wdata;
                    chk("grant_addr", mem_address, cur_addr);
                    chk("grant_read", mem_read, !cur_write);
                    chk("grant_write", mem_write, cur_write);
                    if (cur_write) chk("grant_wdata", mem_wdata, cur_wdata);
                    delay = slow ? 8 : $urandom_range(0, 3);
                    if (cur == DCACHE) d_in_service = 1;
                end
            end else if (spur) begin
                pulse = 1;
                spur  = 0;
            end
            @(posedge clk);
            #1;
            if (fire) begin
                mem_rdata = rand_line();
                mem_resp  = 1'b1;
                if (!phantom) resp_q.push_back('{cur, mem_rdata});
                resp_now  = 1;
            end else if (pulse) begin
                mem_rdata = rand_line();
                mem_resp  = 1'b1;
                resp_now  = 0;
            end else begin
                mem_resp  = 1'b0;
                resp_now  = 0;
            end
        end
    end

    // Cache-side response monitor.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (i_resp || d_resp) begin
                if (resp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: i_resp=%0b d_resp=%0b expected none", i_resp, d_resp);
                end else begin
                    e = resp_q.pop_front();
                    chk("resp_i", i_resp, e.who == ICACHE);
                    chk("resp_d", d_resp, e.who == DCACHE);
                    chk("resp_rdata", (e.who == ICACHE) ? i_rdata : d_rdata, e.data);
                    chk("other_rdata_zero", (e.who == ICACHE) ? d_rdata : i_rdata, '0);
                end
            end
        end
    end

    task automatic raise_i();
        exp_i_addr = $urandom;
        i_address  = exp_i_addr;
        i_read     = 1'b1;
    endtask

    // mode: 0 random op, 1 fixed write-back, 2 read
    task automatic raise_d(input int mode);
        bit w;
        if (mode == 1) begin
            w           = 1;
            exp_d_addr  = 32'h0000_0100;
            exp_d_wdata = {32{8'hA5}};
        end else begin
            w           = (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            exp_d_addr  = $urandom;
            exp_d_wdata = rand_line();
        end
        exp_d_write = w;
        d_address   = exp_d_addr;
        d_wdata     = exp_d_wdata;
        d_read      = !w;
        d_write     = w;
    endtask

    task automatic run_round(input int ci, input int cd, input int dmode);
        int  mi = ci, md = cd, cyc;
        bit  gi, gd, gap_i = 0, gap_d = 0, done = 0;
        arb_req_t pick;
        while (mi > 0 || md > 0) begin
            if (mi > 0 && md > 0) pick = (model_last == ICACHE) ? DCACHE : ICACHE;
            else if (mi > 0)      pick = ICACHE;
            else                  pick = DCACHE;
            grant_q.push_back(pick);
            model_last = pick;
            if (pick == ICACHE) mi--;
            else md--;
        end
        @(posedge clk);
        #1;
        if (ci > 0) begin raise_i(); ci--; end
        if (cd > 0) begin raise_d(dmode); cd--; end
        for (cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            gi = i_resp;
            gd = d_resp;
            @(posedge clk);
            #1;
            if (gap_i) begin
                gap_i = 0;
                if (ci > 0) begin raise_i(); ci--; end
            end else if (gi) begin
                i_read = 1'b0;
                gap_i  = 1;
            end
            if (gap_d) begin
                gap_d = 0;
                if (cd > 0) begin raise_d(dmode); cd--; end
            end else if (gd) begin
                d_read  = 1'b0;
                d_write = 1'b0;
                gap_d   = 1;
            end else if (d_in_service && (d_read || d_write)) begin
                d_address = $urandom;
                d_wdata   = rand_line();
            end
            if (!i_read && !d_read && !d_write && !gap_i && !gap_d && ci == 0 && cd == 0) begin
                done = 1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL round_timeout: round not complete after %0d cycles, required completion", cyc);
            i_read  = 1'b0;
            d_read  = 1'b0;
            d_write = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic spur_check(input string tag);
        @(posedge clk);
        #1;
        spur = 1;
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_no_i_resp"}, i_resp, 1'b0);
        chk({tag, "_no_d_resp"}, d_resp, 1'b0);
        @(negedge clk);
        chk({tag, "_still_idle"}, {mem_read, mem_write}, 2'b00);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_address = '0; d_address = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_mem_address", mem_address, '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        chk("rst_resp", {i_resp, d_resp}, 2'b00);
        chk("rst_rdata", i_rdata | d_rdata, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        spur_check("idle_spur");

        // Single I-cache read with exact latency.
        grant_q.push_back(ICACHE);
        model_last = ICACHE;
        @(posedge clk);
        #1;
        exp_i_addr = 32'h0000_0064;
        i_address  = exp_i_addr;
        i_read     = 1'b1;
        @(negedge clk);
        chk("t0_mem_read_low", mem_read, 1'b0);
        @(negedge clk);
        chk("t1_mem_read_high", mem_read, 1'b1);
        chk("t1_mem_address", mem_address, 32'h0000_0060);
        n = 0;
        while (!i_resp && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t1_resp_seen", i_resp, 1'b1);
        @(posedge clk);
        #1;
        i_read = 1'b0;
        @(negedge clk);
        chk("t1_idle_after", {mem_read, mem_write}, 2'b00);

        // Reset in the middle of a D-cache read; a late mem_resp must be ignored.
        slow = 1;
        grant_q.push_back(DCACHE);
        @(posedge clk);
        #1;
        raise_d(2);
        n = 0;
        while (!d_in_service && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t5_in_service", d_in_service, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        d_read = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        slow = 0;
        model_last = ICACHE;
        @(negedge clk);
        chk("t5_mem_dropped", {mem_read, mem_write}, 2'b00);
        spur_check("late_resp");

        // Simultaneous continuous requests after reset: D first, then alternation.
        run_round(2, 2, 0);

        // Write-back with data scrambled mid-transaction.
        slow = 1;
        run_round(0, 1, 1);
        slow = 0;

        for (int r = 0; r < 30; r++) begin
            int ci = $urandom_range(0, 3);
            int cd = $urandom_range(0, 3);
            if (ci == 0 && cd == 0) ci = 1;
            run_round(ci, cd, 0);
        end

        repeat (5) @(negedge clk);
        chk("grant_q_drained", grant_q.size(), 0);
        chk("resp_q_drained", resp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
